// File: rtl/loader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// loader_pkg: shared state encoding and length helpers for prog_loader.
// Rev 1.0
// ----------------------------------------------------------------------------
package loader_pkg;

  typedef enum logic [2:0] {
    LEN   = 3'd0,
    DATA  = 3'd1,
    SUM   = 3'd2,
    FLUSH = 3'd3,
    RUN   = 3'd4,
    ERROR = 3'd5
  } state_e;

  // A length byte of zero encodes a full 256-byte image.
  localparam logic [7:0] LEN_WRAP_256 = 8'h00;

  function automatic logic [7:0] last_index(input logic [7:0] len);
    return (len == LEN_WRAP_256) ? 8'hFF : len - 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/loader_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// loader_counter: 8-bit byte index / write address with last-byte detect.
// Rev 1.0
// ----------------------------------------------------------------------------
module loader_counter
  import loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] len_i,
  input  logic       inc_i,
  output logic [7:0] idx_o,
  output logic       last_o
);

  logic [7:0] idx_q;
  logic [7:0] last_idx_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q      <= 8'h00;
      last_idx_q <= 8'h00;
    end else if (load_i) begin
      idx_q      <= 8'h00;
      last_idx_q <= last_index(len_i);
    end else if (inc_i) begin
      idx_q      <= idx_q + 8'd1;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == last_idx_q);

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// prog_loader: length-prefixed byte-stream loader for nic8 program memory.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined. Rev 1.0
// ----------------------------------------------------------------------------
module prog_loader
  import loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       cpu_reset,
  output logic       done,
  output logic       error
);

  state_e     state_q;
  logic       mem_we_q;
  logic [7:0] mem_addr_q;
  logic [7:0] mem_data_q;

  logic       fire;
  logic       take_len;
  logic       take_data;
  logic [7:0] idx;
  logic       last;

  assign in_ready  = (state_q == LEN) || (state_q == DATA) ||
                     (state_q == SUM) || (state_q == ERROR);
  assign fire      = in_valid && in_ready;
  assign take_len  = fire && ((state_q == LEN) || (state_q == ERROR));
  assign take_data = fire && (state_q == DATA);

  loader_counter u_counter (
    .clk    (clk),
    .reset  (reset),
    .load_i (take_len),
    .len_i  (in_data),
    .inc_i  (take_data),
    .idx_o  (idx),
    .last_o (last)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= 8'h00;
    end else if (take_len) begin
      sum_q <= 8'h00;
    end else if (take_data) begin
      sum_q <= sum_q + in_data;
    end
  end

  assign error = (state_q == ERROR);
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LEN;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 8'h00;
      mem_data_q <= 8'h00;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        LEN, ERROR: begin
          if (fire) state_q <= DATA;
        end
        DATA: begin
          if (fire) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= idx;
            mem_data_q <= in_data;
`ifdef LOADER_CHECKSUM_EN
            if (last) state_q <= SUM;
`else
            // The strobe for this last byte is still live during FLUSH.
            if (last) state_q <= FLUSH;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        SUM: begin
          if (fire) state_q <= (in_data == sum_q) ? FLUSH : ERROR;
        end
`endif
        FLUSH:   state_q <= RUN;
        RUN:     state_q <= RUN;
        default: state_q <= LEN;
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign cpu_reset = (state_q != RUN);
  assign done      = (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_prog_loader: randomized and directed loads checked against an image model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       cpu_reset;
  logic       done;
  logic       error;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference image: byte i of the stream must land at address i.
  logic [7:0] img [0:255];

  // Observation logs: every write strobe and every accepted byte, stamped.
  logic [7:0] wlog_a [0:4095];
  logic [7:0] wlog_d [0:4095];
  int         wlog_t [0:4095];
  int         clog_t [0:4095];
  int         wn = 0;
  int         cn = 0;
  int         ncyc = 0;
  int         err_cycles = 0;

  always @(negedge clk) begin
    if (mem_we && wn < 4096) begin
      wlog_a[wn] = mem_addr;
      wlog_d[wn] = mem_data;
      wlog_t[wn] = ncyc;
      wn++;
    end
    if (in_valid && in_ready && cn < 4096) begin
      clog_t[cn] = ncyc;
      cn++;
    end
    if (error) err_cycles++;
    ncyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h (failure %0d)", tag, obs, exp, n_fail);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "/in_ready"},  32'(in_ready),  32'd1);
    check({tag, "/mem_we"},    32'(mem_we),    32'd0);
    check({tag, "/mem_addr"},  32'(mem_addr),  32'h00);
    check({tag, "/mem_data"},  32'(mem_data),  32'h00);
    check({tag, "/cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "/done"},      32'(done),      32'd0);
    check({tag, "/error"},     32'(error),     32'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 of the consuming edge.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready) begin
      waited++;
      if (waited > 20) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_byte: in_ready got 0 required 1 within 20 cycles");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "handshake timeout");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    check_reset("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Streams length, image (and checksum) and checks the resulting writes.
  task automatic run_load(input int n, input int gap_pct, input string tag);
    int         wb;
    int         cb;
    int         extra;
    logic [7:0] s;
    wb = wn;
    cb = cn;
    s  = 8'h00;
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      if (i > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_byte(img[i]);
      s = s + img[i];
    end
    extra = 1;
`ifdef LOADER_CHECKSUM_EN
    send_byte(s);
    extra = 2;
`endif
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "/flush_done"},     32'(done),      32'd0);
    check({tag, "/flush_cpu_rst"},  32'(cpu_reset), 32'd1);
    check({tag, "/flush_ready"},    32'(in_ready),  32'd0);
    check({tag, "/flush_error"},    32'(error),     32'd0);
    @(negedge clk);
    check({tag, "/run_done"},       32'(done),      32'd1);
    check({tag, "/run_cpu_rst"},    32'(cpu_reset), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    repeat (3) @(negedge clk);
    check({tag, "/run_ready"},      32'(in_ready),  32'd0);
    check({tag, "/run_we"},         32'(mem_we),    32'd0);
    check({tag, "/run_done_hold"},  32'(done),      32'd1);
    in_valid = 1'b0;
    check({tag, "/n_writes"},       32'(wn - wb),   32'(n));
    check({tag, "/n_accepted"},     32'(cn - cb),   32'(n + extra));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s/w%0d", tag, i),
            {wlog_a[wb + i], wlog_d[wb + i], 16'(wlog_t[wb + i])},
            {8'(i), img[i], 16'(clog_t[cb + 1 + i] + 1)});
    end
  endtask

  initial begin
    #2_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: time limit reached, got running required finished");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    reset = 1'b0;

    img[0] = 8'hC3;
    img[1] = 8'h3C;
    run_load(2, 0, "c33c");

    for (int t = 0; t < 3; t++) begin
      do_reset();
      n = int'($urandom_range(1, 40));
      for (int i = 0; i < n; i++) img[i] = 8'($urandom);
      run_load(n, 40, $sformatf("rnd%0d", t));
    end

    do_reset();
    for (int i = 0; i < 256; i++) img[i] = 8'(i);
    run_load(256, 0, "len256");

    do_reset();
    send_byte(8'h04);
    send_byte(8'hA1);
    send_byte(8'hB2);
    check("mid/we_live", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    check_reset("mid");
    @(posedge clk);
    #1;
    reset  = 1'b0;
    img[0] = 8'h5A;
    run_load(1, 0, "after_rst");

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'hFF);
    in_valid = 1'b0;
    @(negedge clk);
    check("bad/error",     32'(error),     32'd1);
    check("bad/cpu_reset", 32'(cpu_reset), 32'd1);
    check("bad/in_ready",  32'(in_ready),  32'd1);
    check("bad/done",      32'(done),      32'd0);
    @(posedge clk);
    #1;
    img[0] = 8'hAA;
    run_load(1, 0, "recover");
`else
    check("never_error", 32'(err_cycles), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
